// File: rtl/game_pkg.sv
// Shared game-wide constants and types: direction bit indices, sprite sizes,
// play-area bounds and the collision-scan state encoding.
package game_pkg;
  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;

  localparam int HERO_SIDE_DEF  = 60;
  localparam int BLOCK_SIDE_DEF = 60;

  localparam int PLAY_X_MIN = 62;
  localparam int PLAY_X_MAX = 962;
  localparam int PLAY_Y_MIN = 108;
  localparam int PLAY_Y_MAX = 708;

  localparam int COORD_W = 12;
  localparam int EVAL_W  = 13;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} scan_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;
endpackage

// File: rtl/rect_probe.sv
// One-pixel probe rectangle vs block overlap test. The probe origin is the hero
// origin shifted by (DX,DY); negative shifts become +1 on the block side.
module rect_probe
  import game_pkg::*;
#(
  parameter int DX         = 0,
  parameter int DY         = 0,
  parameter int HERO_SIDE  = HERO_SIDE_DEF,
  parameter int BLOCK_SIDE = BLOCK_SIDE_DEF
) (
  input  point_t probe_org_i,
  input  point_t block_org_i,
  input  logic   block_valid_i,
  output logic   hit_o
);
  localparam logic [EVAL_W-1:0] HS     = EVAL_W'(HERO_SIDE);
  localparam logic [EVAL_W-1:0] BS     = EVAL_W'(BLOCK_SIDE);
  localparam logic [EVAL_W-1:0] PX_INC = (DX > 0) ? EVAL_W'(1) : EVAL_W'(0);
  localparam logic [EVAL_W-1:0] BX_INC = (DX < 0) ? EVAL_W'(1) : EVAL_W'(0);
  localparam logic [EVAL_W-1:0] PY_INC = (DY > 0) ? EVAL_W'(1) : EVAL_W'(0);
  localparam logic [EVAL_W-1:0] BY_INC = (DY < 0) ? EVAL_W'(1) : EVAL_W'(0);

  logic [EVAL_W-1:0] px, py, bx, by;
  logic              x_ok, y_ok;

  assign px = {1'b0, probe_org_i.x} + PX_INC;
  assign py = {1'b0, probe_org_i.y} + PY_INC;
  assign bx = {1'b0, block_org_i.x} + BX_INC;
  assign by = {1'b0, block_org_i.y} + BY_INC;

  // Strict inequalities: touching edges overlap once the probe has moved a pixel.
  assign x_ok  = (px < bx + BS) && (bx < px + HS);
  assign y_ok  = (py < by + BS) && (by < py + HS);
  assign hit_o = block_valid_i && x_ok && y_ok;
endmodule

// File: rtl/hero_collision_scan.sv
// Sweeps the block map once per start pulse and publishes which of the four
// hero directions are blocked; feeds the hero movement controller.
module hero_collision_scan
  import game_pkg::*;
#(
  parameter int NUM_BLOCKS = 16,
  parameter int ADDR_W     = 4,
  parameter int HERO_SIDE  = HERO_SIDE_DEF,
  parameter int BLOCK_SIDE = BLOCK_SIDE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [11:0]       hero_x,
  input  logic [11:0]       hero_y,
  output logic [ADDR_W-1:0] block_addr,
  input  logic [11:0]       block_x,
  input  logic [11:0]       block_y,
  input  logic              block_valid,
  output logic [3:0]        collision,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BLOCKS - 1);

  scan_state_e       state_q;
  point_t            hero_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        acc_q, coll_q, hits, acc_d;
  logic              busy_q, done_q, eval_en;
  point_t            blk;

  assign blk = '{x: block_x, y: block_y};

  rect_probe #(.DX(-1), .DY(0), .HERO_SIDE(HERO_SIDE), .BLOCK_SIDE(BLOCK_SIDE)) u_left (
    .probe_org_i(hero_q), .block_org_i(blk), .block_valid_i(block_valid), .hit_o(hits[DIR_LEFT]));
  rect_probe #(.DX(1), .DY(0), .HERO_SIDE(HERO_SIDE), .BLOCK_SIDE(BLOCK_SIDE)) u_right (
    .probe_org_i(hero_q), .block_org_i(blk), .block_valid_i(block_valid), .hit_o(hits[DIR_RIGHT]));
  rect_probe #(.DX(0), .DY(1), .HERO_SIDE(HERO_SIDE), .BLOCK_SIDE(BLOCK_SIDE)) u_down (
    .probe_org_i(hero_q), .block_org_i(blk), .block_valid_i(block_valid), .hit_o(hits[DIR_DOWN]));
  rect_probe #(.DX(0), .DY(-1), .HERO_SIDE(HERO_SIDE), .BLOCK_SIDE(BLOCK_SIDE)) u_up (
    .probe_org_i(hero_q), .block_org_i(blk), .block_valid_i(block_valid), .hit_o(hits[DIR_UP]));

  // Read data trails the address by a cycle, so the first SCAN cycle has nothing to test.
  assign eval_en = ((state_q == ST_SCAN) && (addr_q != '0)) || (state_q == ST_DRAIN);
  assign acc_d   = acc_q | (eval_en ? hits : 4'b0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hero_q  <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
      coll_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SCAN;
            hero_q  <= '{x: hero_x, y: hero_y};
            acc_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SCAN: begin
          acc_q <= acc_d;
          if (addr_q == LAST_ADDR) state_q <= ST_DRAIN;
          else                     addr_q  <= addr_q + 1'b1;
        end
        ST_DRAIN: begin
          coll_q  <= acc_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          addr_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign block_addr = addr_q;
  assign collision  = coll_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: doc/hero_collision_scan.md
Name: hero_collision_scan

Overview:
- Upstream feeder of the hero movement controller: produces its 4-bit `collision` input.
- On each `start` pulse:
  - snapshots the hero position;
  - sweeps the block map, one entry per clk cycle, through a synchronous 1-cycle-latency read port;
  - tests four one-pixel probe rectangles (up/down/left/right) against every valid block;
  - publishes the accumulated blocked-direction flags.

Parameters:
- NUM_BLOCKS, 16, number of block-map entries swept (>=2).
- ADDR_W, 4, width of block_addr; must satisfy 2**ADDR_W >= NUM_BLOCKS.
- HERO_SIDE, 60, hero square side in pixels.
- BLOCK_SIDE, 60, block square side in pixels.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle sweep request; sampled only in IDLE.
- hero_x  in  12  hero top-left x, pixels.
- hero_y  in  12  hero top-left y, pixels.
- block_addr  out  ADDR_W  block-map read address.
- block_x  in  12  block top-left x; valid 1 cycle after block_addr.
- block_y  in  12  block top-left y; valid 1 cycle after block_addr.
- block_valid  in  1  entry in use; valid 1 cycle after block_addr.
- collision  out  4  [0]=left, [1]=right, [2]=down, [3]=up blocked.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse; collision updated this cycle.

Behaviour:
- Reset values: collision=0, block_addr=0, busy=0, done=0, accumulator=0, state=IDLE.
- States: IDLE, SCAN, DRAIN.
- IDLE:
  - start=1 -> SCAN; latch hero_x/hero_y into hx/hy; clear accumulator; block_addr=0.
  - start=0 -> stay.
- SCAN:
  - busy=1.
  - block_addr increments by 1 each cycle.
  - When block_addr==NUM_BLOCKS-1 -> DRAIN.
- DRAIN:
  - busy=1.
  - Evaluates the last entry.
  - Next cycle: collision <= accumulator | last hits, done=1, busy=0, state=IDLE, block_addr=0.
- Evaluation: every cycle from the first SCAN cycle +1 through DRAIN, the returned entry (if block_valid) is ORed into the accumulator. Entries with block_valid=0 contribute nothing.
- Latency: start sampled at edge t0 -> done=1 and new collision in cycle t0+NUM_BLOCKS+2.
- Probe test: overlap of probe P with block B is P.x0 < B.x0+BS && B.x0 < P.x0+HS && P.y0 < B.y0+BS && B.y0 < P.y0+HS, with HS=HERO_SIDE and BS=BLOCK_SIDE.
- Probe origins:
  - up: (hx, hy-1)
  - down: (hx, hy+1)
  - left: (hx-1, hy)
  - right: (hx+1, hy)
- Arithmetic: all computed in 13-bit unsigned. The -1 terms are rewritten as an add on the other side (e.g. hy < B.y0+BS+1), so no underflow at coordinate 0.
- Edge contact counts as blocked: hero right edge adjacent to block left edge sets right.
- collision holds its value between sweeps. It is not cleared at sweep start, only replaced at done.
- start while busy is ignored; no queueing.
- hero_x/hero_y changes during a sweep have no effect (snapshot).
- Reset mid-sweep: immediate abort; all outputs return to reset values; no done pulse.

Decomposition:
- Shared package game_pkg:
  - direction bit indices DIR_LEFT=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_UP=3;
  - HERO_SIDE/BLOCK_SIDE defaults;
  - play-area bounds 62/962/108/708.
- One combinational sub-module, rect_probe:
  - inputs: probe origin, block origin, block_valid;
  - output: 1-bit overlap.
  - Instantiated four times.

Test Plan (HERO_SIDE=BLOCK_SIDE=60, NUM_BLOCKS=4, hero=(481,648), unused entries block_valid=0):
- Block at (541,648) valid, pulse start at cycle 0 -> done=1 in cycle 6, collision=4'b0010.
- Block at (481,588) -> collision=4'b1000; blocks at (421,648) and (481,708) -> 4'b0101.
- Block at (542,648) (one-pixel gap) -> 4'b0000; same block with block_valid=0 -> 4'b0000.
- Start pulsed again during a sweep (cycle 2) -> single done at cycle 6; no second sweep. Previous collision held until cycle 6. hero_x changed mid-sweep -> result uses snapshot.
- Assert rst at cycle 3 of a sweep -> collision=0, busy=0, block_addr=0 immediately. No done. Next start completes normally.
- Hero at (0,0) with block at (0,60) -> collision=4'b0100, no underflow false hits.
